status_register: RTL

- Stage directly downstream of the ALU.
- Captures the ALU result into the adder-hold register and maintains the 6502 processor status register P (N V 1 B D I Z C) from the ALU flag outputs, the data bus, and explicit set/clear commands.
- Drives the ALU carry-in select back upstream.
- Supplies P to the push path and the decimal/interrupt-disable bits to the control unit.

---
 rtl/control_signals_pkg.sv | 39 +++
 rtl/status_register.sv | 121 ++++++++++++
 2 files changed

// File: rtl/control_signals_pkg.sv
// Shared control encodings for the ALU / status-register datapath:
// flag update sources, ALU carry-in selects, P bit indices and reset value.
package control_signals;

    typedef enum logic [1:0] {
        FLAG_HOLD = 2'd0,
        FLAG_ALU  = 2'd1,
        FLAG_BUS  = 2'd2,
        FLAG_BIT  = 2'd3
    } flag_src_t;

    typedef enum logic [1:0] {
        CARRY_ZERO = 2'd0,
        CARRY_ONE  = 2'd1,
        CARRY_P    = 2'd2
    } carry_sel_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_U = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    localparam logic [7:0] P_RESET_DEFAULT = 8'h24;

    // Only six bits of P have storage; B and the unused bit are synthesised on read.
    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } pflags_t;

endpackage

// File: rtl/status_register.sv
// ALU result hold register and 6502 processor status register P.
// Optional macro STATUS_CMOS_DECIMAL_CLEAR_EN: interrupt entry also clears D.
module status_register
    import control_signals::*;
#(
    parameter logic [7:0] P_RESET = P_RESET_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_negative,
    input  logic       alu_overflow,
    input  logic [7:0] data_bus_in,
    input  logic       hold_load,
    input  flag_src_t  flag_src,
    input  logic [7:0] flag_mask,
    input  logic [7:0] set_mask,
    input  logic [7:0] clear_mask,
    input  logic       irq_entry,
    input  logic       push_brk,
    input  carry_sel_t carry_sel,
    output logic [7:0] hold_out,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       carry_to_alu,
    output logic       decimal_mode,
    output logic       irq_disable
);

    pflags_t    p_q, p_d;
    logic [7:0] hold_q, hold_d;

    // Bits 5:4 of the masks and bus have no storage behind them.
    logic unused_bits;
    assign unused_bits = ^{flag_mask[5:2], data_bus_in[5:4],
                           set_mask[5:4], clear_mask[5:4]};

    // Next-state: source select, then clear, then set, then interrupt entry.
    always_comb begin
        p_d    = p_q;
        hold_d = hold_load ? alu_out : hold_q;

        case (flag_src)
            FLAG_ALU: begin
                if (flag_mask[FLAG_C]) p_d.c = alu_carry;
                if (flag_mask[FLAG_Z]) p_d.z = alu_zero;
                if (flag_mask[FLAG_V]) p_d.v = alu_overflow;
                if (flag_mask[FLAG_N]) p_d.n = alu_negative;
            end
            FLAG_BUS: begin
                p_d.n = data_bus_in[FLAG_N];
                p_d.v = data_bus_in[FLAG_V];
                p_d.d = data_bus_in[FLAG_D];
                p_d.i = data_bus_in[FLAG_I];
                p_d.z = data_bus_in[FLAG_Z];
                p_d.c = data_bus_in[FLAG_C];
            end
            FLAG_BIT: begin
                p_d.n = data_bus_in[FLAG_N];
                p_d.v = data_bus_in[FLAG_V];
                p_d.z = alu_zero;
            end
            default: p_d = p_q;
        endcase

        if (clear_mask[FLAG_N]) p_d.n = 1'b0;
        if (clear_mask[FLAG_V]) p_d.v = 1'b0;
        if (clear_mask[FLAG_D]) p_d.d = 1'b0;
        if (clear_mask[FLAG_I]) p_d.i = 1'b0;
        if (clear_mask[FLAG_Z]) p_d.z = 1'b0;
        if (clear_mask[FLAG_C]) p_d.c = 1'b0;

        if (set_mask[FLAG_N]) p_d.n = 1'b1;
        if (set_mask[FLAG_V]) p_d.v = 1'b1;
        if (set_mask[FLAG_D]) p_d.d = 1'b1;
        if (set_mask[FLAG_I]) p_d.i = 1'b1;
        if (set_mask[FLAG_Z]) p_d.z = 1'b1;
        if (set_mask[FLAG_C]) p_d.c = 1'b1;

        if (irq_entry) begin
            p_d.i = 1'b1;
`ifdef STATUS_CMOS_DECIMAL_CLEAR_EN
            p_d.d = 1'b0;
`endif
        end
    end

    // Register P and the hold value; reset aborts any pending update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q.n  <= P_RESET[FLAG_N];
            p_q.v  <= P_RESET[FLAG_V];
            p_q.d  <= P_RESET[FLAG_D];
            p_q.i  <= P_RESET[FLAG_I];
            p_q.z  <= P_RESET[FLAG_Z];
            p_q.c  <= P_RESET[FLAG_C];
            hold_q <= 8'h00;
        end else begin
            p_q    <= p_d;
            hold_q <= hold_d;
        end
    end

    // Carry-in uses the pre-update C so read-modify-write ops see the old value.
    always_comb begin
        case (carry_sel)
            CARRY_ONE: carry_to_alu = 1'b1;
            CARRY_P:   carry_to_alu = p_q.c;
            default:   carry_to_alu = 1'b0;
        endcase
    end

    assign hold_out     = hold_q;
    assign p_out        = {p_q.n, p_q.v, 1'b1, 1'b0, p_q.d, p_q.i, p_q.z, p_q.c};
    assign p_push       = {p_q.n, p_q.v, 1'b1, push_brk, p_q.d, p_q.i, p_q.z, p_q.c};
    assign decimal_mode = p_q.d;
    assign irq_disable  = p_q.i;

endmodule
